mac_operand_sequencer: RTL and testbench

- Upstream feeder for the 8x8->16 MAC unit.
- Holds one row vector A and one column vector B of VEC_LEN 8-bit elements, loaded through a write port.
- On start: clears the MAC, streams the element pairs into it one per cycle, captures the 16-bit accumulator, and offers it downstream with a valid/ready handshake.
- Forms one dot-product lane of the matrix multiply accelerator.

---
 rtl/mma_pkg.sv | 19 +
 rtl/mac_operand_buffer.sv | 41 ++++
 rtl/mac_operand_sequencer.sv | 147 ++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mma_pkg.sv
// Shared constants and types for the matrix-multiply accelerator lanes.
// Used by the operand sequencer and its operand buffer.
package mma_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        HOLD
    } seq_state_t;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/mac_operand_buffer.sv
// Two-bank operand register file (row vector A, column vector B) with one
// write port and two combinational read ports sharing a single index.
module mac_operand_buffer #(
    parameter int VEC_LEN = 4,
    parameter int DATA_W  = mma_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [$clog2(VEC_LEN)-1:0] wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [$clog2(VEC_LEN)-1:0] rd_idx,
    output logic [DATA_W-1:0]          rd_a,
    output logic [DATA_W-1:0]          rd_b
);
    import mma_pkg::*;

    logic [DATA_W-1:0] bank_a [VEC_LEN];
    logic [DATA_W-1:0] bank_b [VEC_LEN];

    // Addresses past VEC_LEN-1 are only reachable for non-power-of-two lengths.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                bank_a[i] <= '0;
                bank_b[i] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < VEC_LEN)) begin
            if (wr_sel == BANK_A) begin
                bank_a[wr_addr] <= wr_data;
            end else begin
                bank_b[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_a = bank_a[rd_idx];
    assign rd_b = bank_b[rd_idx];

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds one dot-product lane: clears the external MAC, streams A/B pairs into
// it one per cycle, then captures the accumulator behind a valid/ready hold.
module mac_operand_sequencer #(
    parameter int VEC_LEN = 4,
    parameter int DATA_W  = mma_pkg::DATA_W,
    parameter int ACC_W   = mma_pkg::ACC_W,
    parameter int MAC_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [$clog2(VEC_LEN)-1:0] wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       mac_clear,
    output logic                       mac_enable,
    output logic [DATA_W-1:0]          mac_a,
    output logic [DATA_W-1:0]          mac_b,
    input  logic [ACC_W-1:0]           mac_acc,
    output logic [ACC_W-1:0]           result,
    output logic                       result_valid,
    input  logic                       result_ready
);
    import mma_pkg::*;

    localparam int AW  = $clog2(VEC_LEN);
    localparam int DCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [AW-1:0]  IDX_LAST   = AW'(VEC_LEN - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(MAC_LAT - 1);

    seq_state_t        state, state_nxt;
    logic [AW-1:0]     idx, idx_nxt;
    logic [DCW-1:0]    drain_cnt, drain_nxt;
    logic              clear_nxt, enable_nxt, valid_nxt;
    logic [DATA_W-1:0] a_nxt, b_nxt;
    logic [ACC_W-1:0]  result_nxt;

    logic              buf_wr_en;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_a, rd_b;

    // Operands may only change while no run is using them.
    assign buf_wr_en = wr_en && (state == IDLE);

    // Read one element ahead so the registered mac_a/mac_b carry no bubble.
    assign rd_idx = (state == STREAM && idx != IDX_LAST) ? idx + 1'b1 : '0;

    mac_operand_buffer #(
        .VEC_LEN (VEC_LEN),
        .DATA_W  (DATA_W)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        drain_nxt  = drain_cnt;
        clear_nxt  = 1'b0;
        enable_nxt = 1'b0;
        a_nxt      = '0;
        b_nxt      = '0;
        result_nxt = result;
        valid_nxt  = result_valid;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                    clear_nxt = 1'b1;
                end
            end
            CLEAR: begin
                state_nxt  = STREAM;
                idx_nxt    = '0;
                enable_nxt = 1'b1;
                a_nxt      = rd_a;
                b_nxt      = rd_b;
            end
            STREAM: begin
                if (idx == IDX_LAST) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end else begin
                    idx_nxt    = idx + 1'b1;
                    enable_nxt = 1'b1;
                    a_nxt      = rd_a;
                    b_nxt      = rd_b;
                end
            end
            DRAIN: begin
                // The last enabled edge needs MAC_LAT cycles to reach acc_out.
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt  = HOLD;
                    result_nxt = mac_acc;
                    valid_nxt  = 1'b1;
                end else begin
                    drain_nxt = drain_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            drain_cnt    <= '0;
            busy         <= 1'b0;
            mac_clear    <= 1'b0;
            mac_enable   <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            drain_cnt    <= drain_nxt;
            busy         <= (state_nxt != IDLE);
            mac_clear    <= clear_nxt;
            mac_enable   <= enable_nxt;
            mac_a        <= a_nxt;
            mac_b        <= b_nxt;
            result       <= result_nxt;
            result_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer driving a behavioural 8x8->16 MAC
// with one cycle of latency (clear has priority over enable).
`timescale 1ns/1ps
module tb_mac_operand_sequencer;

    localparam int VEC_LEN = 4;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 16;
    localparam int MAC_LAT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic              wr_sel;
    logic [1:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              busy;
    logic              mac_clear;
    logic              mac_enable;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_acc;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_operand_sequencer #(
        .VEC_LEN (VEC_LEN),
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .busy         (busy),
        .mac_clear    (mac_clear),
        .mac_enable   (mac_enable),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_acc      (mac_acc),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    // Bench MAC: not tied to the sequencer reset, so partial sums survive it.
    always_ff @(posedge clk) begin
        if (mac_clear) begin
            mac_acc <= '0;
        end else if (mac_enable) begin
            mac_acc <= mac_acc + {8'd0, mac_a} * {8'd0, mac_b};
        end
    end

    task automatic write_elem(input logic sel, input logic [1:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Element i sits at bits [8*i +: 8].
    task automatic load(input logic [31:0] a_vec, input logic [31:0] b_vec);
        for (int i = 0; i < VEC_LEN; i++) begin
            write_elem(1'b0, 2'(i), a_vec[8*i +: 8]);
            write_elem(1'b1, 2'(i), b_vec[8*i +: 8]);
        end
    endtask

    // Returns the number of edges after the start edge until result_valid.
    task automatic start_and_wait(output int n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; result_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (mac_clear !== 1'b0) begin errors++; $display("FAIL reset_mac_clear: got %0b expected 0", mac_clear); end
        checks++; if (mac_enable !== 1'b0) begin errors++; $display("FAIL reset_mac_enable: got %0b expected 0", mac_enable); end
        checks++; if (mac_a !== 8'd0) begin errors++; $display("FAIL reset_mac_a: got %0d expected 0", mac_a); end
        checks++; if (mac_b !== 8'd0) begin errors++; $display("FAIL reset_mac_b: got %0d expected 0", mac_b); end
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", result_valid); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        ea = '{8'd2, 8'd3, 8'd4, 8'd5};
        eb = '{8'd3, 8'd3, 8'd3, 8'd3};
        load({8'd5, 8'd4, 8'd3, 8'd2}, {8'd3, 8'd3, 8'd3, 8'd3});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (mac_clear !== 1'b1) begin errors++; $display("FAIL basic_clear: got %0b expected 1", mac_clear); end
        checks++; if (mac_enable !== 1'b0) begin errors++; $display("FAIL basic_clear_enable: got %0b expected 0", mac_enable); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", busy); end
        for (int i = 0; i < VEC_LEN; i++) begin
            @(negedge clk);
            checks++; if (mac_enable !== 1'b1) begin errors++; $display("FAIL basic_enable%0d: got %0b expected 1", i, mac_enable); end
            checks++; if (mac_clear !== 1'b0) begin errors++; $display("FAIL basic_clear%0d: got %0b expected 0", i, mac_clear); end
            checks++; if (mac_a !== ea[i]) begin errors++; $display("FAIL basic_a%0d: got %0d expected %0d", i, mac_a, ea[i]); end
            checks++; if (mac_b !== eb[i]) begin errors++; $display("FAIL basic_b%0d: got %0d expected %0d", i, mac_b, eb[i]); end
        end
        @(negedge clk);
        checks++; if (mac_enable !== 1'b0) begin errors++; $display("FAIL basic_drain_enable: got %0b expected 0", mac_enable); end
        checks++; if (mac_a !== 8'd0) begin errors++; $display("FAIL basic_drain_a: got %0d expected 0", mac_a); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b expected 0", result_valid); end
        @(negedge clk);
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", result_valid); end
        checks++; if (result !== 16'd42) begin errors++; $display("FAIL basic_result: got %0d expected 42", result); end
        accept();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b expected 0", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_overflow_wrap();
        int n;
        load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start_and_wait(n);
        checks++; if (n !== 6) begin errors++; $display("FAIL wrap_latency: got %0d expected 6", n); end
        checks++; if (result !== 16'd63492) begin errors++; $display("FAIL wrap_result: got %0d expected 63492", result); end
        accept();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid_drop: got %0b expected 0", result_valid); end
    endtask

    task automatic test_handshake_hold();
        int n;
        load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
        start_and_wait(n);
        checks++; if (result !== 16'd70) begin errors++; $display("FAIL hold_result: got %0d expected 70", result); end
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;
            @(negedge clk);
            checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %0b expected 1", c, result_valid); end
            checks++; if (result !== 16'd70) begin errors++; $display("FAIL hold_stable%0d: got %0d expected 70", c, result); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy%0d: got %0b expected 1", c, busy); end
            checks++; if (mac_clear !== 1'b0) begin errors++; $display("FAIL hold_start_ignored%0d: got %0b expected 0", c, mac_clear); end
        end
        start = 1'b0;
        accept();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_drop: got %0b expected 0", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle: got %0b expected 0", busy); end
        checks++; if (result !== 16'd70) begin errors++; $display("FAIL hold_result_kept: got %0d expected 70", result); end
        checks++; if (mac_clear !== 1'b0) begin errors++; $display("FAIL hold_no_restart: got %0b expected 0", mac_clear); end
    endtask

    task automatic test_write_lockout();
        int n;
        load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        write_elem(1'b0, 2'd3, 8'd9);
        write_elem(1'b0, 2'd0, 8'd9);
        n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (result !== 16'd10) begin errors++; $display("FAIL lockout_result: got %0d expected 10", result); end
        accept();
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'd7;
        start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++; if (mac_a !== 8'd7) begin errors++; $display("FAIL same_cycle_first_a: got %0d expected 7", mac_a); end
        n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (result !== 16'd16) begin errors++; $display("FAIL same_cycle_result: got %0d expected 16", result); end
        accept();
    endtask

    task automatic test_reset_mid_stream();
        int n;
        load({8'd3, 8'd3, 8'd3, 8'd3}, {8'd2, 8'd2, 8'd2, 8'd2});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        checks++; if (mac_enable !== 1'b0) begin errors++; $display("FAIL midrst_enable: got %0b expected 0", mac_enable); end
        checks++; if (mac_clear !== 1'b0) begin errors++; $display("FAIL midrst_clear: got %0b expected 0", mac_clear); end
        checks++; if (mac_a !== 8'd0 || mac_b !== 8'd0) begin errors++; $display("FAIL midrst_operands: got %0d/%0d expected 0/0", mac_a, mac_b); end
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL midrst_result: got %0d expected 0", result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b expected 0", result_valid); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        start_and_wait(n);
        checks++; if (result !== 16'd0) begin errors++; $display("FAIL midrst_banks_cleared: got %0d expected 0", result); end
        accept();
        load({8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1});
        start_and_wait(n);
        checks++; if (result !== 16'd4) begin errors++; $display("FAIL midrst_rerun: got %0d expected 4", result); end
        accept();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [15:0] exp_res [3];
        exp_res = '{16'd20, 16'd26, 16'd22};
        load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd2, 8'd3, 8'd4});
        result_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            start = 1'b1;
            if (r == 1) begin
                wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 2'd0; wr_data = 8'd10;
            end else if (r == 2) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd3; wr_data = 8'd0;
            end
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            n = 0;
            while (result_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++; if (n !== 6) begin errors++; $display("FAIL b2b_latency%0d: got %0d expected 6", r, n); end
            checks++; if (result !== exp_res[r]) begin errors++; $display("FAIL b2b_result%0d: got %0d expected %0d", r, result, exp_res[r]); end
            @(negedge clk);
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL b2b_one_cycle%0d: got %0b expected 0", r, result_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d: got %0b expected 0", r, busy); end
        end
        result_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow_wrap();
        test_handshake_hold();
        test_write_lockout();
        test_reset_mid_stream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
